// File: rtl/cce_b_64_wd_pkg.sv
// Shared types and defaults for the CCE_B_64 deadlock watchdog.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cce_b_64_wd_pkg;

   localparam int CNT_W_DEF    = 32;
   localparam int EVT_W_DEF    = 8;
   localparam int THRESH_D_DEF = 1024;
   localparam int TSTAMP_W     = 48;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SUSPECT  = 2'd1,
      DEADLOCK = 2'd2,
      RECOVER  = 2'd3
   } wd_state_t;

endpackage

// File: rtl/cce_b_64_sat_counter.sv
// Up-counter with synchronous clear; optionally sticks at all-ones instead of wrapping.
// Latency: q reflects inc/clr one clock after they are sampled.
// Backpressure: none; inc is accepted every cycle, clr wins over inc.
module cce_b_64_sat_counter
   import cce_b_64_wd_pkg::*;
#(
   parameter int W   = 8,
   parameter bit SAT = 1'b1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   // Count up on inc; hold at all-ones when saturation is enabled.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && !(SAT && (&q))) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/cce_b_64_deadlock_watchdog.sv
// Qualifies the deadlock monitor's block signal over THRESH consecutive cycles; sticky flag, irq pulse, diagnostics.
// Latency: irq/deadlock/snap_len update on the same edge that samples the qualifying block_in.
// Backpressure: none; block_in is sampled every cycle. Optional timestamp: CCE_B_64_DEADLOCK_WD_TSTAMP_EN.
module cce_b_64_deadlock_watchdog
   import cce_b_64_wd_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int EVT_W    = EVT_W_DEF,
   parameter int THRESH_D = THRESH_D_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             block_in,
   input  logic             thresh_we,
   input  logic [CNT_W-1:0] thresh_wdata,
   input  logic             clear,
   output logic             deadlock,
   output logic             irq,
   output logic [CNT_W-1:0] run_len,
   output logic [CNT_W-1:0] snap_len,
   output logic [EVT_W-1:0] evt_cnt
`ifdef CCE_B_64_DEADLOCK_WD_TSTAMP_EN
   ,
   output logic [TSTAMP_W-1:0] snap_time
`endif
);

   wd_state_t        state;
   wd_state_t        state_nxt;
   logic [CNT_W-1:0] thresh_q;
   logic [CNT_W-1:0] eff_thresh;
   logic [CNT_W-1:0] run_inc;
   logic             detect;
   logic             detect_ok;

   // A programmed threshold of 0 behaves like 1.
   assign eff_thresh = (thresh_q == '0) ? CNT_W'(1) : thresh_q;

   // Next run length as the counter will hold it; the compare must see the saturated value.
   assign run_inc = (&run_len) ? run_len : run_len + CNT_W'(1);

   // run_len is 0 outside SUSPECT/DEADLOCK, so from IDLE or RECOVER run_inc is 1 and a
   // threshold of 1 qualifies on the very first block edge.
   assign detect    = block_in && (state != DEADLOCK) && (run_inc >= eff_thresh);
   assign detect_ok = detect && !clear;

   // Consecutive-block run counter: any low sample or clear restarts the run.
   cce_b_64_sat_counter #(.W(CNT_W), .SAT(1'b1)) u_run_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (block_in),
      .clr   (clear || !block_in),
      .q     (run_len)
   );

   // Detection event counter survives clear; only reset zeroes it.
   cce_b_64_sat_counter #(.W(EVT_W), .SAT(1'b1)) u_evt_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (detect_ok),
      .clr   (1'b0),
      .q     (evt_cnt)
   );

   // Threshold register; a write is seen by the compare starting the following cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         thresh_q <= CNT_W'(THRESH_D);
      end else if (thresh_we) begin
         thresh_q <= thresh_wdata;
      end
   end

   // Next-state decode; clear is applied in the state register so it overrides everything.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, RECOVER: begin
            if (block_in) begin
               state_nxt = detect ? DEADLOCK : SUSPECT;
            end
         end
         SUSPECT: begin
            if (!block_in) begin
               state_nxt = IDLE;
            end else if (detect) begin
               state_nxt = DEADLOCK;
            end
         end
         DEADLOCK: begin
            if (!block_in) begin
               state_nxt = RECOVER;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register with clear taking priority over any transition.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else if (clear) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Sticky flag and entry pulse; a detection coincident with clear is dropped.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         deadlock <= 1'b0;
         irq      <= 1'b0;
      end else begin
         irq <= detect_ok;
         if (clear) begin
            deadlock <= 1'b0;
         end else if (detect) begin
            deadlock <= 1'b1;
         end
      end
   end

   // Run length captured at the detection edge; clear leaves it for software to read.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         snap_len <= '0;
      end else if (detect_ok) begin
         snap_len <= run_inc;
      end
   end

`ifdef CCE_B_64_DEADLOCK_WD_TSTAMP_EN
   logic [TSTAMP_W-1:0] ts_q;

   // Free-running cycle counter that wraps; unaffected by clear.
   cce_b_64_sat_counter #(.W(TSTAMP_W), .SAT(1'b0)) u_ts_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (1'b1),
      .clr   (1'b0),
      .q     (ts_q)
   );

   // Cycle stamp captured alongside snap_len.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         snap_time <= '0;
      end else if (detect_ok) begin
         snap_time <= ts_q;
      end
   end
`endif

endmodule

// File: tb/tb_cce_b_64_deadlock_watchdog.sv
module tb_cce_b_64_deadlock_watchdog;
   import cce_b_64_wd_pkg::*;

   logic        clock;
   logic        reset;

   // Full-width instance
   logic        blk, we, clr;
   logic [31:0] wd;
   logic        dl, irq;
   logic [31:0] run, snap;
   logic [7:0]  evt;

   // Narrow instance for saturation corners
   logic        blk4, we4, clr4;
   logic [3:0]  wd4;
   logic        dl4, irq4;
   logic [3:0]  run4, snap4;
   logic [1:0]  evt4;

`ifdef CCE_B_64_DEADLOCK_WD_TSTAMP_EN
   logic [47:0] stamp_a, stamp_b;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   cce_b_64_deadlock_watchdog dut (
`ifdef CCE_B_64_DEADLOCK_WD_TSTAMP_EN
      .snap_time    (stamp_a),
`endif
      .clock        (clock),
      .reset        (reset),
      .block_in     (blk),
      .thresh_we    (we),
      .thresh_wdata (wd),
      .clear        (clr),
      .deadlock     (dl),
      .irq          (irq),
      .run_len      (run),
      .snap_len     (snap),
      .evt_cnt      (evt)
   );

   cce_b_64_deadlock_watchdog #(.CNT_W(4), .EVT_W(2), .THRESH_D(1)) dut4 (
`ifdef CCE_B_64_DEADLOCK_WD_TSTAMP_EN
      .snap_time    (stamp_b),
`endif
      .clock        (clock),
      .reset        (reset),
      .block_in     (blk4),
      .thresh_we    (we4),
      .thresh_wdata (wd4),
      .clear        (clr4),
      .deadlock     (dl4),
      .irq          (irq4),
      .run_len      (run4),
      .snap_len     (snap4),
      .evt_cnt      (evt4)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic        blk;
      logic        we;
      logic [31:0] wd;
      logic        clr;
      logic        irq;
      logic        dl;
      logic [31:0] run;
      logic [31:0] snap;
      logic [7:0]  evt;
      wd_state_t   st;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   task automatic add(input logic b, input logic w, input logic [31:0] d, input logic c,
                      input logic i, input logic l, input logic [31:0] r,
                      input logic [31:0] s, input logic [7:0] e, input wd_state_t st);
      vec_t v;
      v.blk = b; v.we = w; v.wd = d; v.clr = c;
      v.irq = i; v.dl = l; v.run = r; v.snap = s; v.evt = e; v.st = st;
      tbl.push_back(v);
   endtask

   task automatic check(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %0h, expected %0h", nm, idx, act, exp);
      end
   endtask

   initial begin
      vec_t e;
      reset = 1'b1;
      blk = 0; we = 0; wd = '0; clr = 0;
      blk4 = 0; we4 = 0; wd4 = '0; clr4 = 0;
      #2 reset = 1'b0;
      #1;
      check("rst_deadlock", 0, 64'(dl), 64'd0);
      check("rst_irq",      0, 64'(irq), 64'd0);
      check("rst_run",      0, 64'(run), 64'd0);
      check("rst_snap",     0, 64'(snap), 64'd0);
      check("rst_evt",      0, 64'(evt), 64'd0);
      check("rst_state",    0, 64'(dut.state), 64'(IDLE));
      @(negedge clock);
      reset = 1'b1;

      // blk we wd clr | irq dl run snap evt state
      add(0,1,4,0,  0,0,0,0,0,IDLE);
      add(1,0,0,0,  0,0,1,0,0,SUSPECT);
      add(1,0,0,0,  0,0,2,0,0,SUSPECT);
      add(1,0,0,0,  0,0,3,0,0,SUSPECT);
      add(0,0,0,0,  0,0,0,0,0,IDLE);
      add(1,0,0,0,  0,0,1,0,0,SUSPECT);
      add(1,0,0,0,  0,0,2,0,0,SUSPECT);
      add(1,0,0,0,  0,0,3,0,0,SUSPECT);
      add(1,0,0,0,  1,1,4,4,1,DEADLOCK);
      add(1,0,0,0,  0,1,5,4,1,DEADLOCK);
      add(0,0,0,0,  0,1,0,4,1,RECOVER);
      add(0,0,0,0,  0,1,0,4,1,RECOVER);
      add(1,0,0,0,  0,1,1,4,1,SUSPECT);
      add(1,0,0,0,  0,1,2,4,1,SUSPECT);
      add(1,0,0,0,  0,1,3,4,1,SUSPECT);
      add(1,0,0,0,  1,1,4,4,2,DEADLOCK);
      add(0,0,0,0,  0,1,0,4,2,RECOVER);
      add(0,0,0,1,  0,0,0,4,2,IDLE);
      add(1,0,0,0,  0,0,1,4,2,SUSPECT);
      add(1,0,0,0,  0,0,2,4,2,SUSPECT);
      add(1,0,0,0,  0,0,3,4,2,SUSPECT);
      add(1,0,0,1,  0,0,0,4,2,IDLE);
      add(1,0,0,0,  0,0,1,4,2,SUSPECT);
      add(0,1,0,0,  0,0,0,4,2,IDLE);
      add(1,0,0,0,  1,1,1,1,3,DEADLOCK);
      add(0,0,0,0,  0,1,0,1,3,RECOVER);
      add(0,0,0,1,  0,0,0,1,3,IDLE);
      add(0,1,10,0, 0,0,0,1,3,IDLE);
      add(1,0,0,0,  0,0,1,1,3,SUSPECT);
      add(1,0,0,0,  0,0,2,1,3,SUSPECT);
      add(1,0,0,0,  0,0,3,1,3,SUSPECT);
      add(1,1,2,0,  0,0,4,1,3,SUSPECT);
      add(1,0,0,0,  1,1,5,5,4,DEADLOCK);
      add(0,0,0,1,  0,0,0,5,4,IDLE);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clock);
         blk = tbl[i].blk; we = tbl[i].we; wd = tbl[i].wd; clr = tbl[i].clr;
         exp_q.push_back(tbl[i]);
         @(posedge clock);
         #1;
         e = exp_q.pop_front();
         check("irq",      i, 64'(irq),  64'(e.irq));
         check("deadlock", i, 64'(dl),   64'(e.dl));
         check("run_len",  i, 64'(run),  64'(e.run));
         check("snap_len", i, 64'(snap), 64'(e.snap));
         check("evt_cnt",  i, 64'(evt),  64'(e.evt));
         check("state",    i, 64'(dut.state), 64'(e.st));
      end
      @(negedge clock);
      blk = 0; we = 0; clr = 0;

      // Narrow instance: thresh 15, hold block, saturate, then async reset mid-run.
      we4 = 1; wd4 = 4'd15;
      @(negedge clock);
      we4 = 0; blk4 = 1;
      for (int k = 1; k <= 17; k++) begin
         @(posedge clock);
         #1;
         check("sat_run",  k, 64'(run4), 64'((k < 15) ? k : 15));
         check("sat_irq",  k, 64'(irq4), 64'(k == 15));
         check("sat_dl",   k, 64'(dl4),  64'(k >= 15));
         if (k == 15) begin
            check("sat_snap", k, 64'(snap4), 64'd15);
            check("sat_evt",  k, 64'(evt4),  64'd1);
         end
      end
      #2 reset = 1'b0;
      #1;
      check("arst_run",  0, 64'(run4),  64'd0);
      check("arst_dl",   0, 64'(dl4),   64'd0);
      check("arst_irq",  0, 64'(irq4),  64'd0);
      check("arst_snap", 0, 64'(snap4), 64'd0);
      check("arst_evt",  0, 64'(evt4),  64'd0);
      check("arst_st",   0, 64'(dut4.state), 64'(IDLE));
      @(negedge clock);
      reset = 1'b1;
      blk4 = 0;

      // Reset threshold of 1: every isolated block edge detects; evt_cnt sticks at 3.
      for (int k = 1; k <= 4; k++) begin
         @(negedge clock);
         blk4 = 1;
         @(posedge clock);
         #1;
         check("evt_irq", k, 64'(irq4), 64'd1);
         check("evt_sat", k, 64'(evt4), 64'((k < 3) ? k : 3));
         @(negedge clock);
         blk4 = 0;
         @(posedge clock);
         #1;
         check("evt_irq_off", k, 64'(irq4), 64'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
